seg7_scroller: RTL and testbench
================================

SEG7_SCROLLER -- requirements
Module: seg7_scroller

Interface
REQ-001 Parameter NUM_DIGITS, default 8: number of seven-segment digits driven.
REQ-002 Parameter MSG_DIGITS, default 16: message length in hex nibbles; must be at least 2.
REQ-003 Parameter TICK_DIV, default 50000000: clock cycles per scroll tick; must be at least 2.
REQ-004 Port CLOCK_50, input, 1: the only clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Port load_valid, input, 1: a new message is offered on load_data.
REQ-007 Port load_data, input, 4*MSG_DIGITS: message; nibble 0 is load_data[3:0].
REQ-008 Port load_ready, output, 1: the block can accept a message.
REQ-009 Port mode, input, 2: 00 static, 01 scroll-left, 10 scroll-right, 11 freeze.
REQ-010 Port HEX, output, 7*NUM_DIGITS: digit i occupies HEX[7i+6:7i]; digit 0 is the rightmost display.
REQ-011 Port wrap_pulse, output, 1: one-cycle strobe when the scroll offset wraps.

Function
REQ-012 The block SHALL implement two states: EMPTY (no message held) and RUN (message held).
REQ-013 load_ready SHALL be 1 in both states; a load is accepted on any edge where load_valid and load_ready are both 1.
REQ-014 On acceptance the block SHALL store load_data, set offset to 0, clear the prescaler and enter RUN.
REQ-015 The prescaler SHALL count 0..TICK_DIV-1 and wrap; a tick is the cycle in which it equals TICK_DIV-1.
REQ-016 Offset behaviour on a tick in RUN, by mode:
- Scroll-left: offset increments modulo MSG_DIGITS.
- Scroll-right: offset decrements modulo MSG_DIGITS.
- Static: offset is cleared to 0.
- Freeze: offset holds.
REQ-017 wrap_pulse SHALL be 1 for the single cycle after a tick that moves offset from MSG_DIGITS-1 to 0 (scroll-left) or from 0 to MSG_DIGITS-1 (scroll-right); no pulse in static or freeze.
REQ-018 When a load and a tick coincide, the load SHALL take priority: offset is 0 and no wrap_pulse is produced.
REQ-019 A mode change SHALL take effect at the next tick; the offset is preserved until then.
REQ-020 In RUN, digit i SHALL display nibble (offset+i) mod MSG_DIGITS; nibbles repeat when NUM_DIGITS > MSG_DIGITS.
REQ-021 In static mode, digit i SHALL display nibble i mod MSG_DIGITS regardless of offset.
REQ-022 In EMPTY, all digits SHALL be blank.
REQ-023 Segment coding SHALL be active-low, bit0=a through bit6=g, standard hex glyphs 0-F; blank is 7'h7F.
REQ-024 HEX SHALL be registered, reflecting message, offset and mode one cycle after they change.

Reset
REQ-025 While reset is high, and immediately on assertion (including mid-scroll), the block SHALL hold:
- state EMPTY, offset 0, prescaler 0;
- every HEX digit 7'h7F, wrap_pulse 0, load_ready 1.
REQ-026 After reset release, the first accepted load SHALL behave exactly as REQ-014.

Configuration
REQ-027 With macro SEG7_SCROLLER_BLINK_EN defined, the following SHALL apply:
- an input blink_mask of width NUM_DIGITS is added;
- a blink phase bit resets to 0 and toggles on every tick;
- while phase is 1, digits whose mask bit is set show 7'h7F.
REQ-028 Without SEG7_SCROLLER_BLINK_EN, blink_mask and the phase logic SHALL be absent and no digit ever blinks.

Verification (NUM_DIGITS=8, MSG_DIGITS=16, TICK_DIV=4)
REQ-029 Reset scenario: assert reset -> all HEX = 7'h7F, load_ready = 1, wrap_pulse = 0.
REQ-030 Static load scenario: load 64'h0123456789ABCDEF in static mode -> HEX0 = glyph F (7'h0E), HEX7 = glyph 8 (7'h00), one cycle after acceptance.
REQ-031 Scroll-left scenario: same message in scroll-left for 16 ticks -> HEX0 steps F, E, D, ... each tick; wrap_pulse is 1 exactly once, after tick 16.
REQ-032 Scroll-right scenario: scroll-right from offset 0 -> first tick gives offset 15, HEX0 = glyph 0, and wrap_pulse fires.
REQ-033 Load/tick collision scenario: load coincides with a tick at offset 5 -> offset 0, no wrap_pulse; reset asserted mid-scroll -> all blank in the same cycle.
REQ-034 Blink scenario (macro defined): blink_mask = 8'h01 -> HEX0 alternates glyph/7'h7F every tick; all other digits stay steady.

Source files
------------

// File: rtl/seg7_scroller_if.sv
// Message load handshake for the seven-segment scroller.
// The master offers a message; the slave reports when it can take one.
interface seg7_scroller_if #(
    parameter int MSG_DIGITS = 16
);
    logic                    load_valid;
    logic [4*MSG_DIGITS-1:0] load_data;
    logic                    load_ready;

    modport master (
        output load_valid,
        output load_data,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_data,
        output load_ready
    );
endinterface

// File: rtl/seg7_scroller.sv
// Seven-segment message scroller: holds a hex message and scrolls it
// across NUM_DIGITS displays. Optional blink: define SEG7_SCROLLER_BLINK_EN.
module seg7_scroller #(
    parameter int NUM_DIGITS = 8,
    parameter int MSG_DIGITS = 16,
    parameter int TICK_DIV   = 50000000
) (
    input  logic                    CLOCK_50,
    input  logic                    reset,
    seg7_scroller_if.slave          load,
    input  logic [1:0]              mode,
`ifdef SEG7_SCROLLER_BLINK_EN
    input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
    output logic [7*NUM_DIGITS-1:0] HEX,
    output logic                    wrap_pulse
);

    localparam int OW = $clog2(MSG_DIGITS);
    localparam int PW = $clog2(TICK_DIV);
    localparam int MW = 4 * MSG_DIGITS;
    localparam int HW = 7 * NUM_DIGITS;

    localparam logic [1:0] M_STATIC = 2'b00;
    localparam logic [1:0] M_LEFT   = 2'b01;
    localparam logic [1:0] M_RIGHT  = 2'b10;
    localparam logic [1:0] M_FREEZE = 2'b11;

    localparam logic [OW-1:0] OFF_LAST = OW'(MSG_DIGITS - 1);
    localparam logic [PW-1:0] PS_LAST  = PW'(TICK_DIV - 1);
    localparam logic [6:0]    BLANK    = 7'h7F;

    typedef enum logic {
        EMPTY,
        RUN
    } state_t;

    state_t          state_q, state_d;
    logic [MW-1:0]   msg_q, msg_d;
    logic [OW-1:0]   off_q, off_d;
    logic [PW-1:0]   ps_q, ps_d;
    logic            wrap_q, wrap_d;
    logic [HW-1:0]   hex_q, hex_d;
    logic            accept;
    logic            tick;
`ifdef SEG7_SCROLLER_BLINK_EN
    logic            phase_q, phase_d;
`endif

    // Active-low segments, bit0 = a .. bit6 = g.
    function automatic logic [6:0] glyph(input logic [3:0] n);
        logic [6:0] g;
        g = BLANK;
        unique case (n)
            4'h0: g = 7'h40;
            4'h1: g = 7'h79;
            4'h2: g = 7'h24;
            4'h3: g = 7'h30;
            4'h4: g = 7'h19;
            4'h5: g = 7'h12;
            4'h6: g = 7'h02;
            4'h7: g = 7'h78;
            4'h8: g = 7'h00;
            4'h9: g = 7'h10;
            4'hA: g = 7'h08;
            4'hB: g = 7'h03;
            4'hC: g = 7'h46;
            4'hD: g = 7'h21;
            4'hE: g = 7'h06;
            4'hF: g = 7'h0E;
        endcase
        return g;
    endfunction

    // Ready never drops, so any valid is an accepted load.
    assign load.load_ready = 1'b1;
    assign accept          = load.load_valid;
    assign tick            = (ps_q == PS_LAST);

    assign HEX        = hex_q;
    assign wrap_pulse = wrap_q;

    // State, message, offset, prescaler and output registers.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            msg_q   <= '0;
            off_q   <= '0;
            ps_q    <= '0;
            wrap_q  <= 1'b0;
            hex_q   <= '1;
`ifdef SEG7_SCROLLER_BLINK_EN
            phase_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            msg_q   <= msg_d;
            off_q   <= off_d;
            ps_q    <= ps_d;
            wrap_q  <= wrap_d;
            hex_q   <= hex_d;
`ifdef SEG7_SCROLLER_BLINK_EN
            phase_q <= phase_d;
`endif
        end
    end

    // Next state: a load beats a coinciding tick and suppresses its wrap.
    always_comb begin
        state_d = state_q;
        msg_d   = msg_q;
        off_d   = off_q;
        ps_d    = tick ? '0 : ps_q + 1'b1;
        wrap_d  = 1'b0;
        if (accept) begin
            state_d = RUN;
            msg_d   = load.load_data;
            off_d   = '0;
            ps_d    = '0;
        end else if (tick && state_q == RUN) begin
            unique case (mode)
                M_LEFT: begin
                    wrap_d = (off_q == OFF_LAST);
                    off_d  = wrap_d ? '0 : off_q + 1'b1;
                end
                M_RIGHT: begin
                    wrap_d = (off_q == '0);
                    off_d  = wrap_d ? OFF_LAST : off_q - 1'b1;
                end
                M_STATIC: off_d = '0;
                M_FREEZE: off_d = off_q;
            endcase
        end
    end

`ifdef SEG7_SCROLLER_BLINK_EN
    // Blink phase flips on every prescaler tick.
    always_comb begin
        phase_d = tick ? ~phase_q : phase_q;
    end
`endif

    // Digit image built from the current message, offset and mode.
    always_comb begin
        int         idx;
        logic [6:0] seg;
        hex_d = '1;
        idx   = 0;
        seg   = BLANK;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (mode == M_STATIC) begin
                idx = i % MSG_DIGITS;
            end else begin
                idx = (int'(off_q) + i) % MSG_DIGITS;
            end
            seg = glyph(msg_q[idx*4 +: 4]);
            if (state_q == EMPTY) begin
                seg = BLANK;
            end
`ifdef SEG7_SCROLLER_BLINK_EN
            if (phase_q && blink_mask[i]) begin
                seg = BLANK;
            end
`endif
            hex_d[7*i +: 7] = seg;
        end
    end

endmodule

// File: tb/tb_seg7_scroller.sv
// Randomized scoreboard bench for seg7_scroller.
// A message-level model predicts HEX/wrap_pulse after every clock edge.
module tb_seg7_scroller;

    localparam int ND = 8;
    localparam int MD = 16;
    localparam int TD = 4;
    localparam logic [63:0] MSG = 64'h0123456789ABCDEF;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    mode = 2'b00;
    logic [7*ND-1:0] HEX;
    logic          wrap_pulse;
`ifdef SEG7_SCROLLER_BLINK_EN
    logic [ND-1:0] blink_mask = '0;
`endif

    int total = 0;
    int bad   = 0;

    seg7_scroller_if #(.MSG_DIGITS(MD)) lif ();

    seg7_scroller #(
        .NUM_DIGITS(ND),
        .MSG_DIGITS(MD),
        .TICK_DIV  (TD)
    ) dut (
        .CLOCK_50  (clk),
        .reset     (rst),
        .load      (lif),
        .mode      (mode),
`ifdef SEG7_SCROLLER_BLINK_EN
        .blink_mask(blink_mask),
`endif
        .HEX       (HEX),
        .wrap_pulse(wrap_pulse)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7*ND-1:0] hex;
        logic            wrap;
    } exp_t;

    exp_t q[$];

    logic [6:0] GL [16];
    initial begin
        GL = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        lif.load_valid = 1'b0;
        lif.load_data  = '0;
    end

    // Reference model: message as a nibble array, scroll position as an
    // integer, ticks every TD cycles counted from the last load or reset.
    bit running = 0;
    int nib [MD];
    int off = 0;
    int cyc = 0;
    bit ph  = 0;

    always @(posedge clk) begin : model
        exp_t            e;
        logic [7*ND-1:0] h;
        int              idx;
        bit              tick;
        h = '1;
        e.wrap = 1'b0;
        if (rst) begin
            running = 0;
            off = 0;
            cyc = 0;
            ph = 0;
        end else begin
            for (int i = 0; i < ND; i++) begin
                idx = (mode == 2'b00) ? (i % MD) : ((off + i) % MD);
                h[7*i +: 7] = running ? GL[nib[idx]] : 7'h7F;
`ifdef SEG7_SCROLLER_BLINK_EN
                if (ph && blink_mask[i]) h[7*i +: 7] = 7'h7F;
`endif
            end
            tick = (cyc == TD - 1);
            cyc = (cyc + 1) % TD;
            if (tick) ph = !ph;
            if (lif.load_valid) begin
                for (int k = 0; k < MD; k++)
                    nib[k] = int'(lif.load_data[4*k +: 4]);
                off = 0;
                cyc = 0;
                running = 1;
            end else if (tick && running) begin
                case (mode)
                    2'b01: begin
                        off = off + 1;
                        if (off == MD) begin
                            off = 0;
                            e.wrap = 1'b1;
                        end
                    end
                    2'b10: begin
                        off = off - 1;
                        if (off < 0) begin
                            off = MD - 1;
                            e.wrap = 1'b1;
                        end
                    end
                    2'b00: off = 0;
                    default: ;
                endcase
            end
        end
        e.hex = h;
        q.push_back(e);
    end

    // Monitor: one expected record per edge, compared at the falling edge.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            total++;
            if (HEX !== e.hex) begin
                bad++;
                $display("FAIL hex t=%0t got=%h exp=%h", $time, HEX, e.hex);
            end
            total++;
            if (wrap_pulse !== e.wrap) begin
                bad++;
                $display("FAIL wrap t=%0t got=%b exp=%b",
                         $time, wrap_pulse, e.wrap);
            end
            total++;
            if (lif.load_ready !== 1'b1) begin
                bad++;
                $display("FAIL ready t=%0t got=%b exp=1",
                         $time, lif.load_ready);
            end
        end
    end

    task automatic step(input bit lv, input logic [63:0] d,
                        input logic [1:0] m);
        @(negedge clk);
        #1;
        lif.load_valid = lv;
        lif.load_data  = d;
        mode           = m;
    endtask

    task automatic check_blank(input string tag);
        total++;
        if (HEX !== '1 || wrap_pulse !== 1'b0 || lif.load_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s got hex=%h wrap=%b ready=%b exp hex=all7F wrap=0 ready=1",
                     tag, HEX, wrap_pulse, lif.load_ready);
        end
    endtask

    logic [63:0] rd;
    logic [1:0]  rm;

    initial begin
        repeat (3) step(0, '0, 2'b00);
        #1;
        check_blank("reset_hold");
        @(negedge clk);
        #1;
        rst = 1'b0;

        // Static load, then the long scroll-left run with a wrap.
        step(1, MSG, 2'b00);
        repeat (4) step(0, '0, 2'b00);
        step(1, MSG, 2'b01);
        repeat (127) step(0, '0, 2'b01);
        // Load lands on a tick with offset 15: no wrap allowed.
        step(1, MSG, 2'b01);
        repeat (23) step(0, '0, 2'b01);
        // Load on the tick leaving offset 5.
        step(1, MSG, 2'b01);
        // Scroll right from offset 0 wraps on the first tick.
        repeat (12) step(0, '0, 2'b10);
        repeat (12) step(0, '0, 2'b11);
        repeat (12) step(0, '0, 2'b00);
        repeat (10) step(0, '0, 2'b01);

        // Reset in the middle of scrolling blanks immediately.
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_blank("reset_mid");
        repeat (2) step(0, '0, 2'b01);
        rst = 1'b0;
        repeat (6) step(0, '0, 2'b01);
        check_blank("empty_after_reset");

        // Randomized traffic.
        rm = 2'b01;
        for (int n = 0; n < 800; n++) begin
            rd = {$urandom, $urandom};
            if ($urandom_range(7) == 0) rm = 2'($urandom_range(3));
`ifdef SEG7_SCROLLER_BLINK_EN
            if ($urandom_range(15) == 0) blink_mask = ND'($urandom);
`endif
            step($urandom_range(15) == 0, rd, rm);
            if ($urandom_range(199) == 0) begin
                rst = 1'b1;
                #1;
                check_blank("reset_rand");
                step(0, rd, rm);
                rst = 1'b0;
            end
        end

        repeat (2) step(0, '0, rm);
        @(negedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
